// File: rtl/cpu_32_pkg.sv
// Shared definitions for the cpu_32 core: opcodes, FSM states and instruction field positions.
package cpu_32_pkg;

    localparam int OP_MSB   = 31;
    localparam int OP_LSB   = 28;
    localparam int RD_MSB   = 27;
    localparam int RD_LSB   = 24;
    localparam int RS1_MSB  = 23;
    localparam int RS1_LSB  = 20;
    localparam int RS2_MSB  = 19;
    localparam int RS2_LSB  = 16;
    localparam int IMM_MSB  = 15;
    localparam int IMM_LSB  = 0;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_AND  = 4'h3,
        OP_ORR  = 4'h4,
        OP_EOR  = 4'h5,
        OP_MOV  = 4'h6,
        OP_MOVI = 4'h7,
        OP_LSL  = 4'h8,
        OP_LSR  = 4'h9,
        OP_CMP  = 4'hA,
        OP_LDR  = 4'hB,
        OP_STR  = 4'hC,
        OP_B    = 4'hD,
        OP_BEQ  = 4'hE,
        OP_HALT = 4'hF
    } opcode_t;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALTED
    } state_t;

    // Every ALU-class opcode refreshes N and Z; C and V only change for ADD/SUB/CMP.
    function automatic logic writes_nz(input opcode_t op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_EOR, OP_MOV,
                          OP_MOVI, OP_LSL, OP_LSR, OP_CMP};
    endfunction

endpackage

// File: rtl/cpu_32_ram.sv
// 64K x 32 word-addressed program/data RAM; combinational read, write on rising CLK when rw_ is low.
module cpu_32_ram (
    input  logic        CLK,
    input  logic [15:0] addr,
    input  logic [31:0] wdata,
    input  logic        rw_,
    output logic [31:0] rdata
);

    logic [31:0] mem [0:65535];

    assign rdata = mem[addr];

    always_ff @(posedge CLK) begin
        if (!rw_) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/cpu_32.sv
// Multicycle 32-bit load/store CPU, 2-5 cycles per instruction; no backpressure (internal RAM always ready).
module cpu_32
    import cpu_32_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    output logic [7:0]  PC,
    output logic [15:0] RAM_ADDR,
    output logic [31:0] INSTR_O,
    output logic [31:0] ALU_RES,
    output logic [3:0]  DEST_O,
    output logic [3:0]  SRC1_REG,
    output logic [3:0]  SRC2_REG,
    output logic [31:0] SRC1_DATA_O,
    output logic [31:0] SRC2_DATA_O,
    output logic [31:0] RAM_DATABUS_IN,
    output logic        RAM_RW_,
    output logic [31:0] R0,  output logic [31:0] R1,  output logic [31:0] R2,  output logic [31:0] R3,
    output logic [31:0] R4,  output logic [31:0] R5,  output logic [31:0] R6,  output logic [31:0] R7,
    output logic [31:0] R8,  output logic [31:0] R9,  output logic [31:0] R10, output logic [31:0] R11,
    output logic [31:0] R12, output logic [31:0] R13, output logic [31:0] R14, output logic [31:0] R15,
    output logic [3:0]  NZCV
);

    state_t      state;
    logic [7:0]  pc;
    logic [31:0] instr, alu_res, src1_data, src2_data, ld_data;
    logic [31:0] regs [16];
    logic [3:0]  flags, flags_nxt;
    logic [31:0] ram_rdata, alu_out;
    logic [32:0] add_full, sub_full;
    logic        c_nxt, v_nxt;

    opcode_t     op;
    logic [3:0]  rd, rs1, rs2;
    logic [15:0] imm;

    assign op  = opcode_t'(instr[OP_MSB:OP_LSB]);
    assign rd  = instr[RD_MSB:RD_LSB];
    assign rs1 = instr[RS1_MSB:RS1_LSB];
    assign rs2 = instr[RS2_MSB:RS2_LSB];
    assign imm = instr[IMM_MSB:IMM_LSB];

    always_comb begin
        add_full = {1'b0, src1_data} + {1'b0, src2_data};
        sub_full = {1'b0, src1_data} - {1'b0, src2_data};
        alu_out  = '0;
        c_nxt    = flags[1];
        v_nxt    = flags[0];
        case (op)
            OP_ADD: begin
                alu_out = add_full[31:0];
                c_nxt   = add_full[32];
                v_nxt   = (src1_data[31] == src2_data[31]) && (alu_out[31] != src1_data[31]);
            end
            // C is the inverted borrow, so it is set when rs1 >= rs2 unsigned.
            OP_SUB, OP_CMP: begin
                alu_out = sub_full[31:0];
                c_nxt   = ~sub_full[32];
                v_nxt   = (src1_data[31] != src2_data[31]) && (alu_out[31] != src1_data[31]);
            end
            OP_AND:         alu_out = src1_data & src2_data;
            OP_ORR:         alu_out = src1_data | src2_data;
            OP_EOR:         alu_out = src1_data ^ src2_data;
            OP_MOV:         alu_out = src2_data;
            OP_MOVI:        alu_out = {16'h0000, imm};
            OP_LSL:         alu_out = src1_data << src2_data[4:0];
            OP_LSR:         alu_out = src1_data >> src2_data[4:0];
            OP_LDR, OP_STR: alu_out = src1_data + {16'h0000, imm};
            default:        alu_out = '0;
        endcase
        flags_nxt = writes_nz(op) ? {alu_out[31], (alu_out == 32'h0), c_nxt, v_nxt} : flags;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state     <= S_FETCH;
            pc        <= '0;
            instr     <= '0;
            alu_res   <= '0;
            src1_data <= '0;
            src2_data <= '0;
            ld_data   <= '0;
            flags     <= '0;
            for (int i = 0; i < 16; i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (state)
                S_FETCH: begin
                    instr <= ram_rdata;
                    pc    <= pc + 8'd1;
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    src1_data <= regs[rs1];
                    src2_data <= regs[rs2];
                    case (op)
                        OP_NOP:  state <= S_FETCH;
                        OP_B: begin
                            pc    <= imm[7:0];
                            state <= S_FETCH;
                        end
                        OP_BEQ: begin
                            if (flags[2]) begin
                                pc <= imm[7:0];
                            end
                            state <= S_FETCH;
                        end
                        OP_HALT: state <= S_HALTED;
                        default: state <= S_EXEC;
                    endcase
                end
                S_EXEC: begin
                    alu_res <= alu_out;
                    flags   <= flags_nxt;
                    if (op == OP_CMP) begin
                        state <= S_FETCH;
                    end else if (op == OP_LDR || op == OP_STR) begin
                        state <= S_MEM;
                    end else begin
                        state <= S_WB;
                    end
                end
                S_MEM: begin
                    ld_data <= ram_rdata;
                    state   <= (op == OP_LDR) ? S_WB : S_FETCH;
                end
                S_WB: begin
                    regs[rd] <= (op == OP_LDR) ? ld_data : alu_res;
                    state    <= S_FETCH;
                end
                S_HALTED: state <= S_HALTED;
                default:  state <= S_FETCH;
            endcase
        end
    end

    assign RAM_ADDR       = (state == S_MEM) ? alu_res[15:0] : {8'h00, pc};
    assign RAM_RW_        = !((state == S_MEM) && (op == OP_STR));
    assign RAM_DATABUS_IN = regs[rd];

    cpu_32_ram RAM (
        .CLK   (CLK),
        .addr  (RAM_ADDR),
        .wdata (RAM_DATABUS_IN),
        .rw_   (RAM_RW_),
        .rdata (ram_rdata)
    );

    assign PC          = pc;
    assign INSTR_O     = instr;
    assign ALU_RES     = alu_res;
    assign DEST_O      = rd;
    assign SRC1_REG    = rs1;
    assign SRC2_REG    = rs2;
    assign SRC1_DATA_O = src1_data;
    assign SRC2_DATA_O = src2_data;
    assign NZCV        = flags;

    assign R0  = regs[0];  assign R1  = regs[1];  assign R2  = regs[2];  assign R3  = regs[3];
    assign R4  = regs[4];  assign R5  = regs[5];  assign R6  = regs[6];  assign R7  = regs[7];
    assign R8  = regs[8];  assign R9  = regs[9];  assign R10 = regs[10]; assign R11 = regs[11];
    assign R12 = regs[12]; assign R13 = regs[13]; assign R14 = regs[14]; assign R15 = regs[15];

endmodule

// File: tb/tb_cpu_32.sv
// Bench for cpu_32: directed programs plus random programs checked against an instruction-level model.
module tb_cpu_32;

    logic        CLK;
    logic        RESET;
    logic [7:0]  pc;
    logic [15:0] ram_addr;
    logic [31:0] instr_o, alu_res, src1_data, src2_data, ram_db_in;
    logic [3:0]  dest_o, src1_reg, src2_reg, nzcv;
    logic        ram_rw;
    logic [31:0] r0, r1, r2, r3, r4, r5, r6, r7, r8, r9, r10, r11, r12, r13, r14, r15;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] m_mem [0:65535];
    logic [31:0] m_reg [16];
    logic [7:0]  m_pc;
    logic [3:0]  m_nzcv;

    cpu_32 dut (
        .CLK(CLK), .RESET(RESET), .PC(pc), .RAM_ADDR(ram_addr), .INSTR_O(instr_o),
        .ALU_RES(alu_res), .DEST_O(dest_o), .SRC1_REG(src1_reg), .SRC2_REG(src2_reg),
        .SRC1_DATA_O(src1_data), .SRC2_DATA_O(src2_data), .RAM_DATABUS_IN(ram_db_in),
        .RAM_RW_(ram_rw),
        .R0(r0), .R1(r1), .R2(r2), .R3(r3), .R4(r4), .R5(r5), .R6(r6), .R7(r7),
        .R8(r8), .R9(r9), .R10(r10), .R11(r11), .R12(r12), .R13(r13), .R14(r14), .R15(r15),
        .NZCV(nzcv)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] dreg(input int i);
        case (i)
            0: return r0;   1: return r1;   2: return r2;   3: return r3;
            4: return r4;   5: return r5;   6: return r6;   7: return r7;
            8: return r8;   9: return r9;   10: return r10; 11: return r11;
            12: return r12; 13: return r13; 14: return r14; default: return r15;
        endcase
    endfunction

    function automatic logic [31:0] enc(input logic [3:0] op, input logic [3:0] rd,
                                        input logic [3:0] rs1, input logic [3:0] rs2,
                                        input logic [15:0] imm);
        return {op, rd, rs1, rs2, imm};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clocks(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic do_reset();
        RESET = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b1;
    endtask

    task automatic wr_mem(input logic [15:0] a, input logic [31:0] d);
        dut.RAM.mem[a] = d;
        m_mem[a]       = d;
    endtask

    task automatic load_prog(input logic [31:0] p[$]);
        for (int i = 0; i < 256; i++) begin
            wr_mem(16'(i), (i < p.size()) ? p[i] : 32'h0);
        end
    endtask

    task automatic set_flags(input logic [31:0] r, input logic c, input logic v);
        m_nzcv = {r[31], (r == 32'h0), c, v};
    endtask

    // Instruction-level interpreter; returns the clock count the program needs up to and including HALT.
    task automatic iss_run(output int cycles);
        logic [31:0] ins, a, b, r;
        logic [3:0]  op;
        logic [15:0] imm, ea;
        longint      s;
        m_pc = 0; m_nzcv = 0; cycles = 0;
        for (int i = 0; i < 16; i++) m_reg[i] = 0;
        for (int step = 0; step < 400; step++) begin
            ins = m_mem[{8'h00, m_pc}];
            m_pc = m_pc + 1;
            op = ins[31:28]; imm = ins[15:0];
            a = m_reg[ins[23:20]]; b = m_reg[ins[19:16]];
            ea = a[15:0] + imm;
            case (op)
                4'h1: begin
                    r = a + b; s = longint'($signed(a)) + longint'($signed(b));
                    set_flags(r, r < a, s != longint'($signed(r)));
                    m_reg[ins[27:24]] = r; cycles += 4;
                end
                4'h2, 4'hA: begin
                    r = a - b; s = longint'($signed(a)) - longint'($signed(b));
                    set_flags(r, a >= b, s != longint'($signed(r)));
                    if (op == 4'h2) begin m_reg[ins[27:24]] = r; cycles += 4; end
                    else cycles += 3;
                end
                4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9: begin
                    case (op)
                        4'h3: r = a & b;
                        4'h4: r = a | b;
                        4'h5: r = a ^ b;
                        4'h6: r = b;
                        4'h7: r = {16'h0, imm};
                        4'h8: r = a << b[4:0];
                        default: r = a >> b[4:0];
                    endcase
                    set_flags(r, m_nzcv[1], m_nzcv[0]);
                    m_reg[ins[27:24]] = r; cycles += 4;
                end
                4'hB: begin m_reg[ins[27:24]] = m_mem[ea]; cycles += 5; end
                4'hC: begin m_mem[ea] = m_reg[ins[27:24]]; cycles += 4; end
                4'hD: begin m_pc = imm[7:0]; cycles += 2; end
                4'hE: begin if (m_nzcv[2]) m_pc = imm[7:0]; cycles += 2; end
                4'hF: begin cycles += 2; return; end
                default: cycles += 2;
            endcase
        end
    endtask

    initial begin
        logic [31:0] prog[$];
        logic [3:0]  ops_tbl [13];
        logic [3:0]  op;
        int          cyc, rw_low;
        ops_tbl = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hE};
        RESET = 1'b0;

        // ADD sequence, then HALT freeze.
        prog = {enc(7,1,0,0,5), enc(7,2,0,0,7), enc(1,3,1,2,0), enc(15,0,0,0,0)};
        load_prog(prog);
        do_reset();
        check("rst_pc", {24'h0, pc}, 0);
        check("rst_instr", instr_o, 0);
        check("rst_alu", alu_res, 0);
        check("rst_nzcv", {28'h0, nzcv}, 0);
        check("rst_rw", {31'h0, ram_rw}, 1);
        check("rst_r3", r3, 0);
        clocks(10);
        check("add_pc10", {24'h0, pc}, 3);
        check("add_dest", {28'h0, dest_o}, 3);
        check("add_src1reg", {28'h0, src1_reg}, 1);
        check("add_src2reg", {28'h0, src2_reg}, 2);
        check("add_src1", src1_data, 5);
        check("add_src2", src2_data, 7);
        clocks(1);
        check("add_alu", alu_res, 12);
        clocks(1);
        check("add_r3", r3, 12);
        check("add_nzcv", {28'h0, nzcv}, 0);
        clocks(2);
        check("halt_pc", {24'h0, pc}, 4);
        clocks(20);
        check("halt_pc_frozen", {24'h0, pc}, 4);
        check("halt_r3_frozen", r3, 12);
        check("halt_instr", instr_o, 32'hF000_0000);

        // SUB negative result, then CMP equal.
        prog = {enc(7,1,0,0,3), enc(7,2,0,0,5), enc(2,4,1,2,0), enc(10,0,2,2,0), enc(15,0,0,0,0)};
        load_prog(prog);
        do_reset();
        clocks(12);
        check("sub_r4", r4, 32'hFFFF_FFFE);
        check("sub_nzcv", {28'h0, nzcv}, 4'b1000);
        clocks(3);
        check("cmp_nzcv", {28'h0, nzcv}, 4'b0110);
        check("cmp_r0", r0, 0);

        // STR / LDR round trip, with one write cycle.
        prog = {enc(7,1,0,0,16'h40), enc(7,5,0,0,16'hABCD), enc(12,5,1,0,2), enc(11,6,1,0,2),
                enc(15,0,0,0,0)};
        load_prog(prog);
        wr_mem(16'h42, 32'h0);
        do_reset();
        rw_low = 0;
        for (int i = 0; i < 17; i++) begin
            clocks(1);
            if (ram_rw === 1'b0) rw_low++;
        end
        check("str_rw_cycles", rw_low, 1);
        check("str_mem42", dut.RAM.mem[16'h42], 32'hABCD);
        check("ldr_r6", r6, 32'hABCD);

        // Reset during the LDR memory cycle, then restart.
        do_reset();
        clocks(15);
        check("ldr_mem_addr", {16'h0, ram_addr}, 32'h42);
        RESET = 1'b0;
        #1;
        check("abort_pc", {24'h0, pc}, 0);
        check("abort_addr", {16'h0, ram_addr}, 0);
        check("abort_instr", instr_o, 0);
        check("abort_alu", alu_res, 0);
        check("abort_src1", src1_data, 0);
        check("abort_r1", r1, 0);
        check("abort_r5", r5, 0);
        check("abort_r6", r6, 0);
        check("abort_nzcv", {28'h0, nzcv}, 0);
        check("abort_mem42", dut.RAM.mem[16'h42], 32'hABCD);
        check("abort_prog", dut.RAM.mem[16'h3], enc(11,6,1,0,2));
        @(posedge CLK);
        #1;
        RESET = 1'b1;
        clocks(4);
        check("restart_r1", r1, 32'h40);
        check("restart_pc", {24'h0, pc}, 1);

        // BEQ taken, then not taken.
        prog = {enc(10,0,0,0,0), enc(14,0,0,0,6), enc(7,7,0,0,1), 32'h0, 32'h0, 32'h0,
                enc(7,8,0,0,2), enc(10,0,8,0,0), enc(14,0,0,0,20), enc(7,9,0,0,3), enc(15,0,0,0,0)};
        load_prog(prog);
        do_reset();
        clocks(5);
        check("beq_taken_pc", {24'h0, pc}, 6);
        clocks(9);
        check("beq_fall_pc", {24'h0, pc}, 9);
        clocks(6);
        check("beq_r7_skipped", r7, 0);
        check("beq_r8", r8, 2);
        check("beq_r9", r9, 3);

        // Random programs against the interpreter.
        for (int t = 0; t < 6; t++) begin
            prog = {};
            prog.push_back(enc(7, 15, 0, 0, 16'h1000));
            for (int i = 1; i < 23; i++) begin
                op = ops_tbl[$urandom_range(0, 12)];
                if (op == 4'hE && i + 2 > 23) op = 4'h7;
                if (op == 4'hB || op == 4'hC)
                    prog.push_back(enc(op, 4'($urandom_range(0, 14)), 4'd15, 4'($urandom),
                                       16'($urandom_range(0, 255))));
                else if (op == 4'hE)
                    prog.push_back(enc(op, 4'($urandom), 4'($urandom), 4'($urandom), 16'(i + 2)));
                else
                    prog.push_back(enc(op, 4'($urandom_range(0, 14)), 4'($urandom), 4'($urandom),
                                       16'($urandom)));
            end
            prog.push_back(enc(15, 0, 0, 0, 0));
            RESET = 1'b0;
            load_prog(prog);
            for (int a = 0; a < 256; a++) wr_mem(16'h1000 + 16'(a), $urandom);
            iss_run(cyc);
            do_reset();
            clocks(cyc);
            for (int i = 0; i < 16; i++) check($sformatf("rnd%0d_r%0d", t, i), dreg(i), m_reg[i]);
            check($sformatf("rnd%0d_nzcv", t), {28'h0, nzcv}, {28'h0, m_nzcv});
            check($sformatf("rnd%0d_pc", t), {24'h0, pc}, {24'h0, m_pc});
            clocks(20);
            check($sformatf("rnd%0d_pc_halted", t), {24'h0, pc}, {24'h0, m_pc});
            for (int a = 0; a < 256; a++)
                check($sformatf("rnd%0d_mem%0h", t, a), dut.RAM.mem[16'h1000 + 16'(a)],
                      m_mem[16'h1000 + 16'(a)]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
